// File: rtl/count10_pkg.sv
// Shared constants and types for the decade (BCD digit) counter.
package count10_pkg;

  localparam int COUNT10_MODULUS = 10;
  localparam int COUNT10_WIDTH   = 4;

  typedef logic [COUNT10_WIDTH-1:0] count10_t;

  localparam count10_t COUNT10_MAX = count10_t'(COUNT10_MODULUS - 1);

  function automatic logic count10_is_max(input count10_t value);
    return value == COUNT10_MAX;
  endfunction

endpackage

// File: rtl/count10_dec.sv
// Modulo-MODULUS up-counter with enable and terminal-count carry; one digit of a cascaded decimal counter.
// Optional synchronous parallel load (LD/D) is built when COUNT10_LOAD_EN is defined.
module count10_dec
  import count10_pkg::*;
#(
  parameter int MODULUS = COUNT10_MODULUS,
  parameter int WIDTH   = COUNT10_WIDTH
) (
  input  logic             CLK,
  input  logic             RB,
  input  logic             EN,
`ifdef COUNT10_LOAD_EN
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             CY
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Terminal and illegal values both fall back to zero on the next enabled edge.
  always_comb begin
    q_d = q_q;
`ifdef COUNT10_LOAD_EN
    if (LD) begin
      q_d = (D > MAX_V) ? '0 : D;
    end else if (EN) begin
      q_d = (q_q >= MAX_V) ? '0 : q_q + WIDTH'(1);
    end
`else
    if (EN) begin
      q_d = (q_q >= MAX_V) ? '0 : q_q + WIDTH'(1);
    end
`endif
  end

  always_ff @(posedge CLK or negedge RB) begin
    if (!RB) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign CY = (q_q == MAX_V);

endmodule

// File: tb/tb_count10_dec.sv
// Scoreboard bench for count10_dec: randomized and directed stimulus against an arithmetic modulo-10 model.
// Load-port checks are compiled in when COUNT10_LOAD_EN is defined.
module tb_count10_dec;

  logic       CLK;
  logic       RB;
  logic       EN;
  logic       LD;
  logic [3:0] D;
  logic [3:0] Q;
  logic       CY;

  typedef struct {
    logic [3:0] q;
    logic       cy;
    string      tag;
  } expect_t;

  expect_t expQueue[$];
  event    asyncEv;
  int      checkCount = 0;
  int      passCount  = 0;
  int      modelQ     = 0;

  count10_dec dut (
    .CLK(CLK),
    .RB (RB),
    .EN (EN),
`ifdef COUNT10_LOAD_EN
    .LD (LD),
    .D  (D),
`endif
    .Q  (Q),
    .CY (CY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExpect(input int value, input string tag);
    expect_t e;
    e.q   = 4'(value);
    e.cy  = (value == 9);
    e.tag = tag;
    expQueue.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    checkCount++;
    if (Q !== e.q || CY !== e.cy) begin
      $display("[TB] FAIL %s: got Q=%0d CY=%b, expected Q=%0d CY=%b at %0t",
               e.tag, Q, CY, e.q, e.cy, $time);
    end else begin
      passCount++;
    end
  endtask

  // Drive one clock period of inputs at the falling edge and queue the model's value for the next rising edge.
  task automatic applyStimulus(input logic rb, input logic en, input logic ld,
                               input logic [3:0] d, input string tag);
    @(negedge CLK);
    RB = rb;
    EN = en;
    LD = ld;
    D  = d;
    if (!rb) begin
      modelQ = 0;
`ifdef COUNT10_LOAD_EN
    end else if (ld) begin
      modelQ = (int'(d) < 10) ? int'(d) : 0;
`endif
    end else if (en === 1'b1) begin
      modelQ = (modelQ + 1) % 10;
    end
    pushExpect(modelQ, tag);
  endtask

  task automatic asyncReset(input string tag);
    RB = 1'b0;
    #1;
    modelQ = 0;
    pushExpect(0, tag);
    ->asyncEv;
  endtask

  // Monitor: samples just after every rising edge or asynchronous event and retires queued expectations.
  initial begin
    forever begin
      @(posedge CLK or asyncEv);
      #1;
      while (expQueue.size() > 0) begin
        checkOutput(expQueue.pop_front());
      end
    end
  end

  initial begin
    RB = 1'b1;
    EN = 1'b1;
    LD = 1'b0;
    D  = 4'd0;

    #2;
    asyncReset("power_up_reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, "reset_hold_en1");
    applyStimulus(1'b0, 1'bx, 1'b0, 4'd0, "reset_hold_en_x");

    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "full_cycle");
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, "hold_at_9");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "resume_wrap");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "resume_count");
    end

    for (int i = 0; i < 80; i++) begin
      applyStimulus(($urandom_range(0, 15) != 0), 1'($urandom), 1'b0, 4'd0, "random");
    end

    while (modelQ != 5) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "approach_5");
    end
    @(posedge CLK);
    #3;
    asyncReset("async_mid_count");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, "async_hold_1");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, "async_hold_2");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "release_first_edge");

`ifdef COUNT10_LOAD_EN
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd7,  "load_7");
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd12, "load_illegal");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd3,  "load_beats_en");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd9,  "load_9");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'($urandom), ($urandom_range(0, 3) == 0),
                    4'($urandom), "random_load");
    end
`endif

    @(negedge CLK);
    @(negedge CLK);
    checkCount++;
    if (expQueue.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQueue.size());
    end else begin
      passCount++;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
